// File: rtl/clock_pkg.sv
// clock_pkg: shared time-of-day widths, limits, packed time type and wrap helpers
package clock_pkg;
  localparam int H_W = 5;
  localparam int M_W = 6;
  localparam int S_W = 6;
  localparam logic [H_W-1:0] MAX_H = 5'd23;
  localparam logic [M_W-1:0] MAX_M = 6'd59;
  localparam logic [S_W-1:0] MAX_S = 6'd59;

  typedef struct packed {
    logic [H_W-1:0] h;
    logic [M_W-1:0] m;
    logic [S_W-1:0] s;
  } tod_t;

  function automatic logic [M_W-1:0] wrap_ms(input logic [M_W-1:0] v);
    return v == MAX_M ? '0 : v + 1'b1;
  endfunction

  function automatic logic [H_W-1:0] wrap_h(input logic [H_W-1:0] v);
    return v == MAX_H ? '0 : v + 1'b1;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk to a terminal flag once every TICK_DIV enabled cycles
module tick_prescaler #(
  parameter int TICK_DIV = 100000000,
  parameter int PRE_W    = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic EN,
  input  logic CLR,
  input  logic HOLD,
  output logic terminal
);
  localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] cnt;

  assign terminal = cnt == LAST;

  // Count while enabled; a held terminal keeps its pending tick for the next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (CLR) cnt <= '0;
    else if (EN && !(terminal && HOLD)) cnt <= terminal ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: 24-hour h:m:s counter with load, minute/hour adjust and tick deferral
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int PRE_W    = 27
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           EN,
  input  logic           LOAD,
  input  logic [H_W-1:0] H_SET,
  input  logic [M_W-1:0] M_SET,
  input  logic [S_W-1:0] S_SET,
  input  logic           INC_MIN,
  input  logic           INC_HOUR,
  output logic [H_W-1:0] H_OUT,
  output logic [M_W-1:0] M_OUT,
  output logic [S_W-1:0] S_OUT,
  output logic           SEC_PULSE,
  output logic           DAY_ROLL,
  output logic           LOAD_ERR
);
  tod_t cur, nxt;
  logic load_ok, accept, reject, adj, terminal, tick, day;

  assign load_ok = H_SET <= MAX_H && M_SET <= MAX_M && S_SET <= MAX_S;
  assign accept  = LOAD && load_ok;
  assign reject  = LOAD && !load_ok;
  assign adj     = !LOAD && (INC_MIN || INC_HOUR);
  assign tick    = EN && terminal && !LOAD && !adj;
  assign day     = tick && cur == {MAX_H, MAX_M, MAX_S};

  tick_prescaler #(.TICK_DIV(TICK_DIV), .PRE_W(PRE_W)) u_pre (
    .clk      (clk),
    .reset    (reset),
    .EN       (EN),
    .CLR      (accept),
    .HOLD     (reject || adj),
    .terminal (terminal)
  );

  // Next time: load beats adjust beats tick; adjusts never carry between fields
  always_comb begin
    nxt = cur;
    if (accept) nxt = {H_SET, M_SET, S_SET};
    else if (adj) begin
      nxt.m = INC_MIN ? wrap_ms(cur.m) : cur.m;
      nxt.h = INC_HOUR ? wrap_h(cur.h) : cur.h;
    end else if (tick) begin
      nxt.s = wrap_ms(cur.s);
      nxt.m = cur.s == MAX_S ? wrap_ms(cur.m) : cur.m;
      nxt.h = cur.s == MAX_S && cur.m == MAX_M ? wrap_h(cur.h) : cur.h;
    end
  end

  // Time and one-cycle status pulses, all registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= '0;
      SEC_PULSE <= 1'b0;
      DAY_ROLL  <= 1'b0;
      LOAD_ERR  <= 1'b0;
    end else begin
      cur       <= nxt;
      SEC_PULSE <= tick;
      DAY_ROLL  <= day;
      LOAD_ERR  <= reject;
    end
  end

  assign H_OUT = cur.h;
  assign M_OUT = cur.m;
  assign S_OUT = cur.s;
endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: randomized scoreboard bench against a seconds-of-day reference model
module tb_time_of_day_counter;
  localparam int TD = 4;

  logic       clk = 0, reset = 0, EN = 0, LOAD = 0, INC_MIN = 0, INC_HOUR = 0;
  logic [4:0] H_SET = 0, H_OUT;
  logic [5:0] M_SET = 0, S_SET = 0, M_OUT, S_OUT;
  logic       SEC_PULSE, DAY_ROLL, LOAD_ERR;

  int vectors = 0, miscompares = 0;
  int tod = 0, pre = 0, cyc = 0;
  logic [19:0] q[$];

  time_of_day_counter #(.TICK_DIV(TD), .PRE_W(2)) dut (
    .clk(clk), .reset(reset), .EN(EN), .LOAD(LOAD),
    .H_SET(H_SET), .M_SET(M_SET), .S_SET(S_SET),
    .INC_MIN(INC_MIN), .INC_HOUR(INC_HOUR),
    .H_OUT(H_OUT), .M_OUT(M_OUT), .S_OUT(S_OUT),
    .SEC_PULSE(SEC_PULSE), .DAY_ROLL(DAY_ROLL), .LOAD_ERR(LOAD_ERR)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] pack(input int t, input bit sp, input bit dr, input bit le);
    logic [4:0] h;
    logic [5:0] m, s;
    h = 5'(t / 3600);
    m = 6'((t / 60) % 60);
    s = 6'(t % 60);
    return {h, m, s, sp, dr, le};
  endfunction

  task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the reference model, and queue its expectation
  task automatic step(input bit en, input bit ld, input int hs, input int ms, input int ss,
                      input bit im, input bit ih);
    bit term, sp, dr, le;
    int hh, mm, sc;
    EN = en; LOAD = ld; INC_MIN = im; INC_HOUR = ih;
    H_SET = hs[4:0]; M_SET = ms[5:0]; S_SET = ss[5:0];
    term = pre == TD - 1;
    sp = 0; dr = 0; le = 0;
    if (ld) begin
      if (hs <= 23 && ms <= 59 && ss <= 59) begin
        tod = hs * 3600 + ms * 60 + ss;
        pre = 0;
      end else begin
        le = 1;
        if (en && !term) pre++;
      end
    end else if (im || ih) begin
      hh = tod / 3600; mm = (tod / 60) % 60; sc = tod % 60;
      if (im) mm = (mm + 1) % 60;
      if (ih) hh = (hh + 1) % 24;
      tod = hh * 3600 + mm * 60 + sc;
      if (en && !term) pre++;
    end else if (en) begin
      if (term) begin
        pre = 0;
        tod = (tod + 1) % 86400;
        sp = 1;
        dr = tod == 0;
      end else pre++;
    end
    @(posedge clk);
    q.push_back(pack(tod, sp, dr, le));
    #1;
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) step(en, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ldt(input int h, input int m, input int s);
    step(1, 1, h, m, s, 0, 0);
  endtask

  task automatic rnd(input int n);
    for (int i = 0; i < n; i++)
      step($urandom % 8 != 0, $urandom % 16 == 0, $urandom % 32, $urandom % 64, $urandom % 64,
           $urandom % 10 == 0, $urandom % 12 == 0);
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest queued expectation
  initial forever begin
    @(negedge clk);
    cyc++;
    if (q.size() != 0) chk($sformatf("cycle%0d", cyc), {H_OUT, M_OUT, S_OUT, SEC_PULSE, DAY_ROLL, LOAD_ERR},
                           q.pop_front());
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #3 chk("reset_state", {H_OUT, M_OUT, S_OUT, SEC_PULSE, DAY_ROLL, LOAD_ERR}, 20'h0);
    @(posedge clk); #1 reset = 1;
    run(16, 1);
    ldt(23, 59, 58);
    run(8, 1);
    ldt(12, 60, 0);
    ldt(12, 34, 56);
    run(5, 1);
    ldt(10, 59, 30);
    step(1, 0, 0, 0, 0, 1, 0);
    ldt(23, 20, 10);
    step(1, 0, 0, 0, 0, 0, 1);
    ldt(5, 6, 7);
    run(3, 1);
    step(1, 0, 0, 0, 0, 1, 0);
    run(2, 1);
    ldt(3, 0, 0);
    run(2, 1);
    run(20, 0);
    run(6, 1);
    ldt(23, 59, 59);
    run(3, 1);
    step(1, 1, 30, 10, 10, 0, 0);
    run(2, 1);
    rnd(400);
    @(negedge clk); #1;
    reset = 0; EN = 1;
    #1 chk("async_reset", {H_OUT, M_OUT, S_OUT, SEC_PULSE, DAY_ROLL, LOAD_ERR}, 20'h0);
    @(negedge clk);
    chk("reset_hold", {H_OUT, M_OUT, S_OUT, SEC_PULSE, DAY_ROLL, LOAD_ERR}, 20'h0);
    @(posedge clk); #1 reset = 1;
    tod = 0; pre = 0;
    run(6, 1);
    rnd(40);
    EN = 0; LOAD = 0; INC_MIN = 0; INC_HOUR = 0;
    @(negedge clk); #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
Free-running 24-hour time-of-day counter that produces the H_OUT/M_OUT/S_OUT bus consumed by the alarm comparator and the display path. It divides the system clock down to a 1 Hz tick and advances seconds, minutes and hours with correct wrap. It also accepts a full-time load from the time-set logic and single-step minute/hour adjust pulses.

Parameters:
TICK_DIV, 100000000, system clock cycles per second tick (>=2)
PRE_W, 27, prescaler width; must hold TICK_DIV-1

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
EN  input  1  1 = time runs; 0 = prescaler and time frozen
LOAD  input  1  single-cycle pulse; load H_SET/M_SET/S_SET
H_SET  input  5  hours to load, legal 0..23
M_SET  input  6  minutes to load, legal 0..59
S_SET  input  6  seconds to load, legal 0..59
INC_MIN  input  1  single-cycle pulse (pre-debounced); minute +1
INC_HOUR  input  1  single-cycle pulse (pre-debounced); hour +1
H_OUT  output  5  current hours 0..23
M_OUT  output  6  current minutes 0..59
S_OUT  output  6  current seconds 0..59
SEC_PULSE  output  1  high one cycle when seconds advance by tick
DAY_ROLL  output  1  high one cycle on 23:59:59 -> 00:00:00
LOAD_ERR  output  1  high one cycle when a LOAD is rejected

Behaviour:
- Reset (reset==0, async): prescaler=0; H_OUT=M_OUT=S_OUT=0; SEC_PULSE=DAY_ROLL=LOAD_ERR=0. Release is synchronous to next clk edge. Reset mid-count discards all state.
- Prescaler counts 0..TICK_DIV-1 while EN=1. At count TICK_DIV-1 it is "terminal"; the tick is taken and it wraps to 0. EN=0 holds the prescaler value.
- Tick: S+1; S==59 -> S=0, M+1; M==59 -> M=0, H+1; H==23 -> H=0. All outputs registered, updated on the same edge that consumes the tick. SEC_PULSE asserted that same edge for one cycle. DAY_ROLL is asserted with it only on the 23:59:59 -> 00:00:00 tick.
- Priority per cycle, highest first: LOAD > INC_HOUR/INC_MIN > tick.
- LOAD: if H_SET<=23 and M_SET<=59 and S_SET<=59, load all three and clear the prescaler to 0 on the next edge. Otherwise leave the time unchanged and pulse LOAD_ERR for one cycle; the prescaler is unaffected. A tick coinciding with an accepted LOAD is discarded. A tick coinciding with a rejected LOAD is deferred as below. LOAD and adjust inputs are accepted regardless of EN.
- INC_MIN: M wraps 59->0 with no carry into H; S unchanged. INC_HOUR: H wraps 23->0. Both in the same cycle apply both increments.
- Tick deferral: if an adjust or rejected LOAD occurs while the prescaler is terminal, the prescaler holds at terminal and the tick is taken the next cycle without an adjust. No second is lost.
- SEC_PULSE and DAY_ROLL never assert for LOAD or adjust changes.
- EN deasserted while terminal: tick withheld until EN returns.

Decomposition:
- Shared package clock_pkg: H_W=5, M_W=6, S_W=6, MAX_H=23, MAX_M=59, MAX_S=59. This package is also used by the alarm and time-set blocks.
- One sub-module: tick_prescaler (parameter TICK_DIV; inputs clk, reset, EN, CLR, HOLD; output terminal flag). The time registers, priority mux and wrap logic stay in the top.

Test Plan:
- TICK_DIV=4, reset release, EN=1 for 16 cycles -> SEC_PULSE every 4th cycle; S_OUT reaches 4; H/M stay 0.
- LOAD 23:59:58, run 2 ticks -> 23:59:59, then 00:00:00 with DAY_ROLL and SEC_PULSE high in the same single cycle.
- LOAD with M_SET=60 -> LOAD_ERR one cycle; time unchanged. LOAD 12:34:56 -> outputs 12:34:56; next tick exactly TICK_DIV cycles later.
- Time 10:59:30: INC_MIN -> 10:00:30 (no hour carry). Time 23:xx: INC_HOUR -> 00:xx with no DAY_ROLL.
- INC_MIN on the prescaler-terminal cycle at 05:06:07 -> 05:07:07, then 05:07:08 on the following cycle; total tick count preserved.
- EN=0 for 20 cycles mid-count -> outputs and prescaler frozen. Assert reset asynchronously between edges -> outputs 0 immediately; no SEC_PULSE glitch.
